unified_mem_arbiter: RTL and testbench

Arbiter that shares one single-ported, fixed-latency unified memory between the instruction-fetch (IF) port and the data-memory (DM) port of the pipelined processor. It grants one access at a time, tracks the outstanding read until its data returns, and routes read data back to the owning port. DM has default priority; a starvation counter guarantees IF forward progress. `busy` and the per-port grants drive the pipeline stall logic.

---
 rtl/unified_mem_arbiter.sv | 117 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between the IF and DM ports.
// DM wins by default; a saturating starvation counter hands priority to IF after STARVE_MAX denials.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              Reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam logic [3:0] LatInit   = 4'(MEM_LAT);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic {StIdle, StWait} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       owner_dm_q;
    logic [3:0] starve_q;

    logic in_idle;
    logic if_prio;

    always_comb begin
        // Grants are gated by Reset so nothing leaks out while it is held.
        in_idle   = (state_q == StIdle) && !Reset;
        if_prio   = (starve_q >= StarveMax);
        if_gnt    = in_idle && if_req && (!dm_req || if_prio);
        dm_gnt    = in_idle && dm_req && !(if_req && if_prio);
        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    assign busy = (state_q == StWait);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            owner_dm_q <= 1'b0;
            starve_q   <= '0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;

            if (if_req && !if_gnt) begin
                if (starve_q != 4'hf) begin
                    starve_q <= starve_q + 4'd1;
                end
            end else begin
                starve_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    // Writes complete on the grant itself; only reads occupy the memory.
                    if (if_gnt || (dm_gnt && !dm_we)) begin
                        state_q    <= StWait;
                        cnt_q      <= LatInit;
                        owner_dm_q <= dm_gnt;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (owner_dm_q) begin
                            dm_rdata  <= mem_rdata;
                            dm_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a cycle-count based model of the arbiter.
module tb_unified_mem_arbiter;

    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk;
    logic        Reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    unified_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK      (clk),
        .Reset    (Reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: written contents plus a fixed pattern for never-written words.
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] pipe [MEM_LAT];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        if (a == 32'h40)  return 32'hfeedbeef;
        if (a == 32'h180) return 32'h12345678;
        return {a[15:0] ^ 16'ha5a5, a[15:0]};
    endfunction

    assign mem_rdata = pipe[MEM_LAT-1];

    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        // Junk on non-read cycles exposes sampling at the wrong time.
        pipe[0] <= (mem_en && !mem_we) ? mem_read(mem_addr) : $urandom;
        if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a read occupies the memory for MEM_LAT+1 cycles and
    // completes (rvalid) exactly in the cycle the memory becomes free again.
    int          cyc = 0;
    int          free_at = 0;
    int          done_at = -1;
    int          starve = 0;
    bit          done_dm = 1'b0;
    logic [31:0] done_data = '0;
    logic [31:0] e_if_rd = '0;
    logic [31:0] e_dm_rd = '0;

    always @(negedge clk) begin
        logic        idle, e_ifg, e_dmg, e_ifv, e_dmv;
        logic [31:0] e_addr;
        if (Reset) begin
            chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            chk("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
            chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_dm_rdata", dm_rdata, 32'd0);
            free_at = 0;
            done_at = -1;
            starve  = 0;
            e_if_rd = '0;
            e_dm_rd = '0;
        end else begin
            idle  = (cyc >= free_at);
            e_ifv = (cyc == done_at) && !done_dm;
            e_dmv = (cyc == done_at) && done_dm;
            if (e_ifv) e_if_rd = done_data;
            if (e_dmv) e_dm_rd = done_data;
            e_ifg  = idle && if_req && (!dm_req || starve >= STARVE_MAX);
            e_dmg  = idle && dm_req && !e_ifg;
            e_addr = e_ifg ? if_addr : (e_dmg ? dm_addr : 32'd0);
            chk("if_gnt", {31'd0, if_gnt}, {31'd0, e_ifg});
            chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, e_dmg});
            chk("mem_en", {31'd0, mem_en}, {31'd0, e_ifg | e_dmg});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e_dmg & dm_we});
            chk("mem_addr", mem_addr, e_addr);
            if (!e_ifg) chk("mem_wdata", mem_wdata, e_dmg ? dm_wdata : 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, !idle});
            chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_ifv});
            chk("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, e_dmv});
            chk("if_rdata", if_rdata, e_if_rd);
            chk("dm_rdata", dm_rdata, e_dm_rd);
            if (e_ifg || (e_dmg && !dm_we)) begin
                free_at   = cyc + MEM_LAT + 1;
                done_at   = free_at;
                done_dm   = e_dmg;
                done_data = mem_read(e_addr);
            end
            starve = (if_req && !e_ifg) ? ((starve < 15) ? starve + 1 : 15) : 0;
        end
        cyc++;
    end

    task automatic step(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        Reset    = r;
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = dd;
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    logic        s_rst, s_ifr, s_dmr, s_dmwe;
    logic [31:0] s_ifa, s_dma, s_dmwd;

    initial begin
        Reset = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle_steps(2);

        // Lone DM read
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        chk("t1_dm_gnt_c0", {31'd0, dm_gnt}, 32'd1);
        chk("t1_mem_en_c0", {31'd0, mem_en}, 32'd1);
        chk("t1_mem_addr_c0", mem_addr, 32'h40);
        idle_steps(1);
        chk("t1_busy_c1", {31'd0, busy}, 32'd1);
        idle_steps(1);
        chk("t1_busy_c2", {31'd0, busy}, 32'd1);
        idle_steps(1);
        chk("t1_dm_rvalid_c3", {31'd0, dm_rvalid}, 32'd1);
        chk("t1_dm_rdata_c3", dm_rdata, 32'hfeedbeef);
        chk("t1_if_rvalid_c3", {31'd0, if_rvalid}, 32'd0);

        // Simultaneous IF read and DM write
        step(1'b0, 1'b1, 32'h180, 1'b1, 1'b1, 32'h19c, 32'hcafe);
        chk("t2_dm_gnt_c0", {31'd0, dm_gnt}, 32'd1);
        chk("t2_mem_we_c0", {31'd0, mem_we}, 32'd1);
        chk("t2_mem_wdata_c0", mem_wdata, 32'hcafe);
        step(1'b0, 1'b1, 32'h180, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t2_if_gnt_c1", {31'd0, if_gnt}, 32'd1);
        idle_steps(3);
        chk("t2_if_rvalid_c4", {31'd0, if_rvalid}, 32'd1);
        chk("t2_if_rdata_c4", if_rdata, 32'h12345678);

        // Back-to-back DM writes
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'(i * 4), 32'h100 + 32'(i));
            chk("t3_dm_gnt", {31'd0, dm_gnt}, 32'd1);
            chk("t3_busy", {31'd0, busy}, 32'd0);
        end
        idle_steps(1);

        // Starvation: DM writes every cycle while IF waits
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h300 + 32'(i * 4), 32'(i));
            chk("t4_if_denied", {31'd0, if_gnt}, 32'd0);
            chk("t4_dm_wins", {31'd0, dm_gnt}, 32'd1);
        end
        step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h310, 32'd4);
        chk("t4_if_gnt_c4", {31'd0, if_gnt}, 32'd1);
        chk("t4_dm_held_c4", {31'd0, dm_gnt}, 32'd0);
        // IF reads occupy the memory for cycles 5-6; the cleared counter lets DM win at 7.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 32'h204, 1'b1, 1'b1, 32'h310, 32'd4);
            chk("t4_no_gnt_wait", {30'd0, if_gnt, dm_gnt}, 32'd0);
        end
        step(1'b0, 1'b1, 32'h204, 1'b1, 1'b1, 32'h310, 32'd4);
        chk("t4_dm_gnt_c7", {31'd0, dm_gnt}, 32'd1);
        chk("t4_if_rvalid_c7", {31'd0, if_rvalid}, 32'd1);
        idle_steps(2);

        // Read completion boundary
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h8, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0);
            chk("t5_no_gnt", {30'd0, if_gnt, dm_gnt}, 32'd0);
        end
        step(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t5_dm_rvalid_c3", {31'd0, dm_rvalid}, 32'd1);
        chk("t5_if_gnt_c3", {31'd0, if_gnt}, 32'd1);
        idle_steps(3);

        // Reset mid-read: clears the previously captured dm_rdata as well
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h304, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t6_busy_reset", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
            chk("t6_no_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
            chk("t6_dm_rdata_zero", dm_rdata, 32'd0);
        end
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t6_if_gnt", {31'd0, if_gnt}, 32'd1);
        idle_steps(3);
        chk("t6_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t6_if_rdata", if_rdata, 32'hfeedbeef);

        // Randomized traffic with hold-until-grant requesters and rare resets
        s_rst = 1'b0; s_ifr = 1'b0; s_dmr = 1'b0; s_dmwe = 1'b0;
        s_ifa = '0; s_dma = '0; s_dmwd = '0;
        for (int n = 0; n < 3000; n++) begin
            step(s_rst, s_ifr, s_ifa, s_dmr, s_dmwe, s_dma, s_dmwd);
            s_rst = ($urandom_range(0, 199) == 0);
            if (!s_ifr || if_gnt) begin
                s_ifr = ($urandom_range(0, 9) < 5);
                s_ifa = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            end else if ($urandom_range(0, 29) == 0) begin
                s_ifr = 1'b0;
            end
            if (!s_dmr || dm_gnt) begin
                s_dmr  = ($urandom_range(0, 9) < 6);
                s_dmwe = $urandom_range(0, 1) == 1;
                s_dma  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                s_dmwd = $urandom;
            end else if ($urandom_range(0, 29) == 0) begin
                s_dmr = 1'b0;
            end
        end
        idle_steps(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
